// File: rtl/fifo_rd_unpacker.sv
// Reads IN_WIDTH-bit words from a FIFO and emits them as four OUT_WIDTH beats, low lane first.
// Optional feature: define FIFO_UNPACK_PARITY_EN to add o_parity (XOR of o_data).
module fifo_rd_unpacker #(
    parameter int unsigned IN_WIDTH  = 128,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_empty,
    output logic                 o_rden,
    input  logic [IN_WIDTH-1:0]  i_rddata,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_last,
    output logic                 o_busy,
    output logic [15:0]          o_word_cnt
`ifdef FIFO_UNPACK_PARITY_EN
    ,
    output logic                 o_parity
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

    state_e                      r_state;
    state_e                      w_state_next;
    logic [1:0]                  r_beat;
    logic [3:0][OUT_WIDTH-1:0]   r_word;
    logic [15:0]                 r_word_cnt;
    logic                        w_handshake;
    logic                        w_last_hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat     <= 2'd0;
            r_word     <= '0;
            r_word_cnt <= 16'd0;
        end else begin
            if (r_state == StFetch) begin
                r_word <= i_rddata;
                r_beat <= 2'd0;
            end else if (w_handshake && (r_beat != 2'd3)) begin
                r_beat <= r_beat + 2'd1;
            end
            if (w_last_hs) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  w_state_next = i_empty ? StIdle : StFetch;
            StFetch: w_state_next = StSend;
            StSend: begin
                if (w_last_hs) begin
                    w_state_next = i_empty ? StIdle : StFetch;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs are forced quiet while reset is high, even before the state register clears.
    always_comb begin
        o_valid     = 1'b0;
        o_data      = '0;
        o_last      = 1'b0;
        o_busy      = 1'b0;
        o_word_cnt  = 16'd0;
        o_rden      = 1'b0;
        w_handshake = 1'b0;
        w_last_hs   = 1'b0;
        if (!reset) begin
            o_valid     = (r_state == StSend);
            o_data      = r_word[r_beat];
            o_last      = o_valid && (r_beat == 2'd3);
            o_busy      = (r_state != StIdle);
            o_word_cnt  = r_word_cnt;
            w_handshake = o_valid && i_ready;
            w_last_hs   = w_handshake && (r_beat == 2'd3);
            o_rden      = !i_empty && ((r_state == StIdle) || w_last_hs);
        end
    end

`ifdef FIFO_UNPACK_PARITY_EN
    assign o_parity = ^o_data;
`endif

endmodule

// File: doc/fifo_rd_unpacker.md
FIFO_RD_UNPACKER -- requirements
Module: fifo_rd_unpacker

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 128, meaning FIFO word width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, meaning output beat width; IN_WIDTH SHALL be 4*OUT_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port o_rden  output  1  FIFO read enable, one-cycle pulse per word.
REQ-007 SHALL have port i_rddata  input  IN_WIDTH  FIFO read data, valid the cycle after o_rden.
REQ-008 SHALL have port o_valid  output  1  output beat valid.
REQ-009 SHALL have port i_ready  input  1  downstream accept.
REQ-010 SHALL have port o_data  output  OUT_WIDTH  output beat.
REQ-011 SHALL have port o_last  output  1  high on final beat of a word.
REQ-012 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port o_word_cnt  output  16  count of fully delivered words.

Function
REQ-014 SHALL implement states IDLE, FETCH, SEND; the beat index SHALL be a 2-bit counter.
REQ-015 In IDLE, o_rden SHALL be 1 combinationally when i_empty==0; the next state SHALL be FETCH, else IDLE.
REQ-016 In FETCH, the block SHALL register i_rddata into a word register, clear the beat index to 0, and go to SEND.
REQ-017 In SEND, o_valid SHALL be 1 and o_data SHALL be word[beat*OUT_WIDTH +: OUT_WIDTH], low lane first.
REQ-018 o_last SHALL be 1 in SEND when beat==3, else 0.
REQ-019 A handshake SHALL be o_valid && i_ready.
REQ-020 On a handshake with beat<3, beat SHALL increment and the state SHALL stay SEND.
REQ-021 On a handshake with beat==3, o_word_cnt SHALL increment, wrapping 0xFFFF->0x0000.
REQ-022 On a beat-3 handshake, if i_empty==0 the block SHALL assert o_rden that cycle and go to FETCH; otherwise it SHALL go to IDLE.
REQ-023 Without a handshake, o_data, o_last and beat SHALL hold stable while o_valid is high.
REQ-024 o_rden SHALL never be asserted in two consecutive cycles, nor while i_empty==1.
REQ-025 Peak throughput SHALL be 4 beats per 5 cycles; latency from o_rden to first o_valid SHALL be 2 cycles.

Reset
REQ-026 While reset==1: state IDLE, beat 0, o_rden 0, o_valid 0, o_data 0, o_last 0, o_busy 0, o_word_cnt 0.
REQ-027 Reset asserted mid-word SHALL discard the remaining beats; no o_rden SHALL issue in the reset cycle.
REQ-028 On the first cycle after reset deasserts, the block SHALL start in IDLE and obey REQ-015.

Configuration
REQ-029 Macro FIFO_UNPACK_PARITY_EN, when defined, SHALL add output o_parity (1 bit) equal to the XOR-reduction of o_data; it SHALL be 0 in reset and valid whenever o_valid==1.
REQ-030 Without FIFO_UNPACK_PARITY_EN, the o_parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then i_empty=1 for 10 cycles -> o_rden, o_valid and o_busy remain 0, o_word_cnt=0.
REQ-032 One word 0x00000004_00000003_00000002_00000001 with i_ready=1 -> beats 0x1, 0x2, 0x3, 0x4 on consecutive cycles, o_last only on 0x4, o_word_cnt=1.
REQ-033 Backpressure: i_ready=0 for 3 cycles on beat 2 -> o_data holds 0x00000003 with o_valid high, and no beat is lost or duplicated.
REQ-034 Three back-to-back words with i_empty=0 and i_ready=1 -> 12 beats in 15 cycles, o_rden pulses exactly on each beat-3 handshake, o_word_cnt=3.
REQ-035 Reset pulsed while beat 1 is pending -> the next cycle shows o_valid=0 and o_word_cnt=0, and the remaining beats are never emitted.
REQ-036 With FIFO_UNPACK_PARITY_EN defined, beat 0x00000007 -> o_parity=1 and beat 0x00000003 -> o_parity=0.
